// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and constants for the RV32M mul/div unit
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CALC_CYCLES = 32;
  localparam int LATENCY     = 34;

  localparam logic [31:0] DIV0_Q  = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN = 32'h80000000;
endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);
  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    // Partial remainder shifted left by one, minus the divisor; the top bit is the borrow.
    diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    q_bit    = is_div && !diff[XLEN];
    acc_next = {1'b0, acc[2*XLEN-1:1]};
    if (is_div) begin
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else             acc_next = {acc[2*XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, FSM plus sign handling
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiplies skip CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] In_A,
  input  logic [XLEN-1:0] In_B,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(CALC_CYCLES);

  state_t            state, state_d;
  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] acc, step_acc, prod;
  logic              step_q;
  logic [XLEN-1:0]   opnd, a_q, mag_a, mag_b, fix_sel, fix_res;
  logic [OP_W-1:0]   op_q;
  logic              neg_q, div0_q, ovf_q;
  logic              a_signed, b_signed, a_neg, b_neg, neg_in, in_div0, in_ovf, early, accept;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (op_q[OP_W-1]),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && In_A[XLEN-1];
    b_neg    = b_signed && In_B[XLEN-1];
    mag_a    = a_neg ? -In_A : In_A;
    mag_b    = b_neg ? -In_B : In_B;
    // Remainder follows the dividend sign; products and quotients follow the sign product.
    neg_in   = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    in_div0  = op[OP_W-1] && (In_B == '0);
    in_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (In_A == INT_MIN) && (In_B == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early    = op[OP_W-1] ? (in_div0 || in_ovf) : ((In_A == '0) || (In_B == '0));
`else
    early    = 1'b0;
`endif
    accept   = start && !kill && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = early ? FIX : CALC;
      CALC: begin
        if (kill)                                    state_d = IDLE;
        else if (count == CNT_W'(CALC_CYCLES - 1))   state_d = FIX;
      end
      FIX:  state_d = kill ? IDLE : DONE;
      DONE: state_d = accept ? (early ? FIX : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod    = neg_q ? -acc : acc;
    fix_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (!op_q[OP_W-1])  fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div0_q)    fix_res = op_q[1] ? a_q : DIV0_Q;
    else if (ovf_q)     fix_res = op_q[1] ? '0 : INT_MIN;
    else                fix_res = neg_q ? -fix_sel : fix_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_q    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q   <= op;
        a_q    <= In_A;
        neg_q  <= neg_in;
        div0_q <= in_div0;
        ovf_q  <= in_ovf;
        count  <= '0;
        opnd   <= op[OP_W-1] ? mag_b : mag_a;
        // Multiply: low half holds the multiplier; divide: low half holds the dividend.
        acc    <= early ? '0 : {{XLEN{1'b0}}, (op[OP_W-1] ? mag_a : mag_b)};
      end else if (state == CALC) begin
        acc   <= step_acc | {{(2*XLEN-1){1'b0}}, step_q};
        count <= (state_d == CALC) ? count + 1'b1 : '0;
      end
      if ((state == FIX) && !kill) result <= fix_res;
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);
endmodule
